exu_wb_arb: RTL and testbench
=============================

EXU_WB_ARB -- requirements
Module: exu_wb_arb

Interface
REQ-001 SHALL have parameter NREQ, default 4, number of execution handlers sharing the GPR write port (2..8).
REQ-002 SHALL have parameter XLEN, default `RV_XLEN, GPR data width.
REQ-003 SHALL have port clk  input  1  the single clock; all state on its rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port req_vld  input  NREQ  per-handler writeback request valid.
REQ-006 SHALL have port req_rdy  output  NREQ  per-handler holding slot can accept this cycle.
REQ-007 SHALL have port req_wa  input  NREQ x `RV_GPR_AW  per-handler destination register.
REQ-008 SHALL have port req_wd  input  NREQ x XLEN  per-handler write data.
REQ-009 SHALL have port gpr_mst  exu_gpr_if_t.mst  -  GPR write port; wen/wa/wd driven, ra1/ra2 tied to 0.
REQ-010 SHALL have port wb_busy  output  2**`RV_GPR_AW  register-pending bitmap (only with EXU_WB_BUSY_EN).

Function
REQ-011 SHALL hold one slot per handler (vld, wa, wd); a transfer occurs when req_vld[i] && req_rdy[i], loading slot i at that edge.
REQ-012 SHALL drive req_rdy[i] = !slot_vld[i] || grant[i], allowing back-to-back accepts on one handler.
REQ-013 SHALL grant at most one occupied slot per cycle, round-robin, starting the search at pointer ptr.
REQ-014 SHALL, on grant to slot i, advance ptr to (i+1) mod NREQ at the next edge; ptr holds when nothing is granted.
REQ-015 SHALL drive gpr_mst.wen = 1, wa = slot wa, wd = slot wd combinationally from the granted slot; slot cleared at the same edge unless reloaded.
REQ-016 SHALL give minimum latency of 1 cycle: request accepted at edge N appears on gpr_mst at cycle N+1.
REQ-017 SHALL treat an occupied slot with wa = 0 as drained without a grant: wen stays 0 for it, slot cleared next edge, ptr unaffected, other slots still arbitrated.
REQ-018 SHALL drive gpr_mst.wen = 0, wa = 0, wd = 0 when no slot is granted (no X on outputs).
REQ-019 SHALL keep writes from one handler in acceptance order; writes from different handlers to the same register retire in grant order.
REQ-020 SHALL guarantee each occupied slot is granted within NREQ cycles (starvation-free).

Reset
REQ-021 SHALL, while rst_n is low, clear all slot_vld, set ptr to 0, force gpr_mst.wen = 0 and wb_busy = 0; req_rdy is all ones.
REQ-022 SHALL discard pending slots on reset mid-operation; no write issues in the first cycle after release.

Configuration
REQ-023 SHALL compile in, under macro EXU_WB_BUSY_EN, output wb_busy where bit r = 1 iff any slot is valid with wa = r (bit 0 always 0), registered-state-derived, no combinational path from req_*.
REQ-024 SHALL, without EXU_WB_BUSY_EN, omit the wb_busy port and its logic entirely.

Structure
REQ-025 SHALL place in shared package exu_wb_pkg: NREQ default, enum of handler indices (WB_SRC_ALU=0, WB_SRC_MISC=1, WB_SRC_LSU=2, WB_SRC_CSR=3), slot struct typedef.
REQ-026 SHALL instantiate one sub-module exu_rr_arb (round-robin picker: req vector, ptr in, one-hot grant out, pure combinational).

Verification
REQ-027 SHALL test single request: handler 1 sends wa=5, wd=0x12345678 at edge 0 -> cycle 1 wen=1, wa=5, wd=0x12345678; cycle 2 wen=0.
REQ-028 SHALL test contention: all 4 handlers valid same cycle, ptr=0 -> grants 0,1,2,3 on four consecutive cycles; ptr ends at 0.
REQ-029 SHALL test x0 filter: handler 2 sends wa=0 -> wen never asserted, req_rdy[2] high again after one cycle.
REQ-030 SHALL test back-to-back: handler 0 streams 3 requests with vld held high, others idle -> 3 writes on consecutive cycles, rdy[0] constantly 1.
REQ-031 SHALL test reset mid-operation: 3 slots loaded, rst_n low one cycle -> no wen after release, req_rdy = 4'b1111, ptr = 0.
REQ-032 SHALL test busy map (EXU_WB_BUSY_EN): handlers 0 and 3 both target x7 -> wb_busy[7]=1 until the second write retires, then 0.

Source files
------------

// File: rtl/exu_wb_pkg.sv
// Shared types and constants for the execution-unit GPR writeback arbiter.
`ifndef RV_XLEN
`define RV_XLEN 32
`endif
`ifndef RV_GPR_AW
`define RV_GPR_AW 5
`endif

package exu_wb_pkg;

  localparam int unsigned GPR_AW   = `RV_GPR_AW;
  localparam int unsigned NGPR     = 1 << GPR_AW;
  localparam int unsigned NREQ_DEF = 4;

  typedef enum logic [2:0] {
    WB_SRC_ALU  = 3'd0,
    WB_SRC_MISC = 3'd1,
    WB_SRC_LSU  = 3'd2,
    WB_SRC_CSR  = 3'd3
  } wb_src_e;

  // Slot tag; write data is stored beside it so its width can follow XLEN.
  typedef struct packed {
    logic              vld;
    logic [GPR_AW-1:0] wa;
  } wb_slot_t;

endpackage

// File: rtl/exu_gpr_if.sv
// GPR register-file port bundle: one write port plus two read addresses.
`ifndef RV_XLEN
`define RV_XLEN 32
`endif
`ifndef RV_GPR_AW
`define RV_GPR_AW 5
`endif

interface exu_gpr_if_t #(
  parameter int unsigned XLEN = `RV_XLEN
) ();

  logic                  wen;
  logic [`RV_GPR_AW-1:0] wa;
  logic [XLEN-1:0]       wd;
  logic [`RV_GPR_AW-1:0] ra1;
  logic [`RV_GPR_AW-1:0] ra2;

  modport mst (output wen, wa, wd, ra1, ra2);
  modport slv (input wen, wa, wd, ra1, ra2);

endinterface

// File: rtl/exu_rr_arb.sv
// Combinational round-robin picker: first set request at or after ptr_i wins.

module exu_rr_arb #(
  parameter int unsigned N = 4,
  localparam int unsigned PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req_i,
  input  logic [PW-1:0] ptr_i,
  output logic [N-1:0]  gnt_o
);

  always_comb begin
    logic          found;
    logic [PW-1:0] idx;
    gnt_o = '0;
    found = 1'b0;
    idx   = '0;
    for (int unsigned off = 0; off < N; off++) begin
      idx = PW'((32'(ptr_i) + off) % N);
      if (!found && req_i[idx]) begin
        gnt_o[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/exu_wb_arb.sv
// Arbitrates NREQ execution handlers onto the single GPR write port, one slot each.
// Optional EXU_WB_BUSY_EN adds the wb_busy register-pending bitmap output.
`ifndef RV_XLEN
`define RV_XLEN 32
`endif

module exu_wb_arb
  import exu_wb_pkg::*;
#(
  parameter int unsigned NREQ = NREQ_DEF,
  parameter int unsigned XLEN = `RV_XLEN
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NREQ-1:0]             req_vld,
  output logic [NREQ-1:0]             req_rdy,
  input  logic [NREQ-1:0][GPR_AW-1:0] req_wa,
  input  logic [NREQ-1:0][XLEN-1:0]   req_wd,
`ifdef EXU_WB_BUSY_EN
  output logic [NGPR-1:0]             wb_busy,
`endif
  exu_gpr_if_t.mst                    gpr_mst
);

  localparam int unsigned PW = $clog2(NREQ);

  wb_slot_t [NREQ-1:0]           slot_q;
  logic     [NREQ-1:0][XLEN-1:0] wd_q;
  logic     [PW-1:0]             ptr_q, ptr_d;
  logic     [NREQ-1:0]           elig, drain, gnt, load;
  logic                          wb_wen;
  logic     [GPR_AW-1:0]         wb_wa;
  logic     [XLEN-1:0]           wb_wd;

  // Writes to x0 are dropped: such slots never compete and simply empty.
  always_comb begin
    for (int unsigned i = 0; i < NREQ; i++) begin
      elig[i]    = slot_q[i].vld && (slot_q[i].wa != '0);
      drain[i]   = slot_q[i].vld && (slot_q[i].wa == '0);
      req_rdy[i] = !slot_q[i].vld || gnt[i];
      load[i]    = req_vld[i] && req_rdy[i];
    end
  end

  exu_rr_arb #(
    .N (NREQ)
  ) u_rr_arb (
    .req_i (elig),
    .ptr_i (ptr_q),
    .gnt_o (gnt)
  );

  always_comb begin
    wb_wen = |gnt;
    wb_wa  = '0;
    wb_wd  = '0;
    ptr_d  = ptr_q;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (gnt[i]) begin
        wb_wa = slot_q[i].wa;
        wb_wd = wd_q[i];
        ptr_d = PW'((i + 1) % NREQ);
      end
    end
  end

  assign gpr_mst.wen = wb_wen;
  assign gpr_mst.wa  = wb_wa;
  assign gpr_mst.wd  = wb_wd;
  assign gpr_mst.ra1 = '0;
  assign gpr_mst.ra2 = '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_q <= '0;
      wd_q   <= '0;
      ptr_q  <= '0;
    end else begin
      ptr_q <= ptr_d;
      for (int unsigned i = 0; i < NREQ; i++) begin
        if (load[i]) begin
          slot_q[i].vld <= 1'b1;
          slot_q[i].wa  <= req_wa[i];
          wd_q[i]       <= req_wd[i];
        end else if (gnt[i] || drain[i]) begin
          slot_q[i].vld <= 1'b0;
        end
      end
    end
  end

`ifdef EXU_WB_BUSY_EN
  // Derived from slot state only, so it never depends on this cycle's requests.
  always_comb begin
    wb_busy = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (slot_q[i].vld) wb_busy[slot_q[i].wa] = 1'b1;
    end
    wb_busy[0] = 1'b0;
  end
`endif

endmodule

// File: tb/tb_exu_wb_arb.sv
// Self-checking bench for exu_wb_arb: directed vector table, reset sequences, random run.
`ifndef RV_GPR_AW
`define RV_GPR_AW 5
`endif

module tb_exu_wb_arb;
  import exu_wb_pkg::*;

  localparam int unsigned N  = 4;
  localparam int unsigned AW = `RV_GPR_AW;
  localparam int unsigned DW = 32;
  localparam int unsigned NT = 22;

  logic                     clk;
  logic                     rst_n;
  logic [N-1:0]             req_vld;
  logic [N-1:0]             req_rdy;
  logic [N-1:0][AW-1:0]     req_wa;
  logic [N-1:0][DW-1:0]     req_wd;
`ifdef EXU_WB_BUSY_EN
  logic [(1<<AW)-1:0]       wb_busy;
  logic [(1<<AW)-1:0]       exp_busy;
`endif

  exu_gpr_if_t #(.XLEN(DW)) gpr ();

  exu_wb_arb #(
    .NREQ (N),
    .XLEN (DW)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .req_vld (req_vld),
    .req_rdy (req_rdy),
    .req_wa  (req_wa),
    .req_wd  (req_wd),
`ifdef EXU_WB_BUSY_EN
    .wb_busy (wb_busy),
`endif
    .gpr_mst (gpr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: one pending write per handler plus the rotating search start.
  logic [N-1:0]      m_vld;
  logic [AW-1:0]     m_wa [N];
  logic [DW-1:0]     m_wd [N];
  int                m_ptr;
  int                m_gnt;
  logic              exp_wen;
  logic [AW-1:0]     exp_wa;
  logic [DW-1:0]     exp_wd;
  logic [N-1:0]      exp_rdy;
  logic [N-1:0]      cur_v;
  logic [N-1:0][AW-1:0] cur_a;
  logic [N-1:0][DW-1:0] cur_d;

  typedef struct {
    logic [N-1:0]         vld;
    logic [N-1:0][AW-1:0] wa;
    logic [N-1:0][DW-1:0] wd;
    logic                 ewen;
    logic [AW-1:0]        ewa;
    logic [DW-1:0]        ewd;
    logic [N-1:0]         erdy;
  } vec_t;

  vec_t tbl [NT];

  function automatic vec_t mk(input logic [N-1:0] v, input logic [N-1:0][AW-1:0] a,
                              input logic [N-1:0][DW-1:0] d, input logic ew,
                              input logic [AW-1:0] ewa, input logic [DW-1:0] ewd,
                              input logic [N-1:0] erdy);
    vec_t r;
    r.vld = v; r.wa = a; r.wd = d; r.ewen = ew; r.ewa = ewa; r.ewd = ewd; r.erdy = erdy;
    return r;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_vld = '0;
    m_ptr = 0;
    m_gnt = -1;
  endtask

  task automatic model_eval();
    m_gnt = -1;
    for (int off = 0; off < int'(N); off++) begin
      int k;
      k = (m_ptr + off) % N;
      if (m_gnt < 0 && m_vld[k] && m_wa[k] != '0) m_gnt = k;
    end
    exp_wen = 1'b0;
    exp_wa  = '0;
    exp_wd  = '0;
    if (m_gnt >= 0) begin
      exp_wen = 1'b1;
      exp_wa  = m_wa[m_gnt];
      exp_wd  = m_wd[m_gnt];
    end
    for (int k = 0; k < int'(N); k++) exp_rdy[k] = !m_vld[k] || (k == m_gnt);
`ifdef EXU_WB_BUSY_EN
    exp_busy = '0;
    for (int r = 1; r < (1 << AW); r++)
      for (int k = 0; k < int'(N); k++)
        if (m_vld[k] && int'(m_wa[k]) == r) exp_busy[r] = 1'b1;
`endif
  endtask

  task automatic model_commit();
    for (int k = 0; k < int'(N); k++) begin
      if (cur_v[k] && exp_rdy[k]) begin
        m_vld[k] = 1'b1;
        m_wa[k]  = cur_a[k];
        m_wd[k]  = cur_d[k];
      end else if (k == m_gnt || (m_vld[k] && m_wa[k] == '0)) begin
        m_vld[k] = 1'b0;
      end
    end
    if (m_gnt >= 0) m_ptr = (m_gnt + 1) % N;
  endtask

  // Drive one cycle's requests and compare the DUT against the model.
  task automatic apply(input logic [N-1:0] v, input logic [N-1:0][AW-1:0] a,
                       input logic [N-1:0][DW-1:0] d);
    req_vld = v; req_wa = a; req_wd = d;
    cur_v = v; cur_a = a; cur_d = d;
    #1;
    model_eval();
    check("mdl.wen", 64'(gpr.wen), 64'(exp_wen));
    check("mdl.wa",  64'(gpr.wa),  64'(exp_wa));
    check("mdl.wd",  64'(gpr.wd),  64'(exp_wd));
    check("mdl.rdy", 64'(req_rdy), 64'(exp_rdy));
`ifdef EXU_WB_BUSY_EN
    check("mdl.busy", 64'(wb_busy[31:0]), 64'(exp_busy[31:0]));
`endif
  endtask

  task automatic tick();
    @(posedge clk);
    model_commit();
    #1;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, ".wen"}, 64'(gpr.wen), 64'd0);
    check({tag, ".rdy"}, 64'(req_rdy), 64'hF);
    check({tag, ".ra"},  64'({gpr.ra1, gpr.ra2}), 64'd0);
`ifdef EXU_WB_BUSY_EN
    check({tag, ".busy"}, 64'(wb_busy[31:0]), 64'd0);
`endif
  endtask

  initial begin
    rst_n   = 1'b0;
    req_vld = '0;
    req_wa  = '0;
    req_wd  = '0;
    model_reset();

    tbl[0]  = mk(4'b1111, {5'd4, 5'd3, 5'd2, 5'd1},
                 {32'hA3, 32'hA2, 32'hA1, 32'hA0}, 1'b0, 5'd0, 32'h0, 4'b1111);
    tbl[1]  = mk(4'b0000, '0, '0, 1'b1, 5'd1, 32'hA0, 4'b0001);
    tbl[2]  = mk(4'b0000, '0, '0, 1'b1, 5'd2, 32'hA1, 4'b0011);
    tbl[3]  = mk(4'b0000, '0, '0, 1'b1, 5'd3, 32'hA2, 4'b0111);
    tbl[4]  = mk(4'b0000, '0, '0, 1'b1, 5'd4, 32'hA3, 4'b1111);
    tbl[5]  = mk(4'b1001, {5'd7, 5'd0, 5'd0, 5'd7},
                 {32'hB3, 32'h0, 32'h0, 32'hB0}, 1'b0, 5'd0, 32'h0, 4'b1111);
    tbl[6]  = mk(4'b0000, '0, '0, 1'b1, 5'd7, 32'hB0, 4'b0111);
    tbl[7]  = mk(4'b0000, '0, '0, 1'b1, 5'd7, 32'hB3, 4'b1111);
    tbl[8]  = mk(4'b0010, {5'd0, 5'd0, 5'd5, 5'd0},
                 {32'h0, 32'h0, 32'h12345678, 32'h0}, 1'b0, 5'd0, 32'h0, 4'b1111);
    tbl[9]  = mk(4'b0000, '0, '0, 1'b1, 5'd5, 32'h12345678, 4'b1111);
    tbl[10] = mk(4'b0000, '0, '0, 1'b0, 5'd0, 32'h0, 4'b1111);
    tbl[11] = mk(4'b0100, '0, {32'h0, 32'hDEADBEEF, 32'h0, 32'h0},
                 1'b0, 5'd0, 32'h0, 4'b1111);
    tbl[12] = mk(4'b0000, '0, '0, 1'b0, 5'd0, 32'h0, 4'b1011);
    tbl[13] = mk(4'b0000, '0, '0, 1'b0, 5'd0, 32'h0, 4'b1111);
    tbl[14] = mk(4'b0110, {5'd0, 5'd12, 5'd11, 5'd0},
                 {32'h0, 32'hD2, 32'hD1, 32'h0}, 1'b0, 5'd0, 32'h0, 4'b1111);
    tbl[15] = mk(4'b0000, '0, '0, 1'b1, 5'd12, 32'hD2, 4'b1101);
    tbl[16] = mk(4'b0000, '0, '0, 1'b1, 5'd11, 32'hD1, 4'b1111);
    tbl[17] = mk(4'b0001, {5'd0, 5'd0, 5'd0, 5'd20},
                 {32'h0, 32'h0, 32'h0, 32'hE0}, 1'b0, 5'd0, 32'h0, 4'b1111);
    tbl[18] = mk(4'b0001, {5'd0, 5'd0, 5'd0, 5'd21},
                 {32'h0, 32'h0, 32'h0, 32'hE1}, 1'b1, 5'd20, 32'hE0, 4'b1111);
    tbl[19] = mk(4'b0001, {5'd0, 5'd0, 5'd0, 5'd22},
                 {32'h0, 32'h0, 32'h0, 32'hE2}, 1'b1, 5'd21, 32'hE1, 4'b1111);
    tbl[20] = mk(4'b0000, '0, '0, 1'b1, 5'd22, 32'hE2, 4'b1111);
    tbl[21] = mk(4'b0000, '0, '0, 1'b0, 5'd0, 32'h0, 4'b1111);

    @(posedge clk);
    #1;
    check_reset_state("por");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Directed vectors: contention, shared target, single write, x0, stream.
    for (int i = 0; i < int'(NT); i++) begin
      apply(tbl[i].vld, tbl[i].wa, tbl[i].wd);
      check($sformatf("vec%0d.wen", i), 64'(gpr.wen), 64'(tbl[i].ewen));
      check($sformatf("vec%0d.wa", i),  64'(gpr.wa),  64'(tbl[i].ewa));
      check($sformatf("vec%0d.wd", i),  64'(gpr.wd),  64'(tbl[i].ewd));
      check($sformatf("vec%0d.rdy", i), 64'(req_rdy), 64'(tbl[i].erdy));
      tick();
    end

    // Reset with three slots pending and the pointer away from zero.
    apply(4'b1101, {5'd9, 5'd8, 5'd0, 5'd6}, {32'hC3, 32'hC2, 32'h0, 32'hC0});
    tick();
    rst_n   = 1'b0;
    req_vld = '0;
    #1;
    check_reset_state("mid_rst");
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    apply('0, '0, '0);
    check_reset_state("post_rst");
    tick();
    apply(4'b1111, {5'd4, 5'd3, 5'd2, 5'd1}, {32'hF3, 32'hF2, 32'hF1, 32'hF0});
    tick();
    apply('0, '0, '0);
    check("post_rst.first_grant", 64'(gpr.wa), 64'(int'(WB_SRC_ALU) + 1));
    tick();
    for (int i = 0; i < 4; i++) begin
      apply('0, '0, '0);
      tick();
    end

    // Random traffic with a sprinkling of x0 targets and shared registers.
    for (int c = 0; c < 600; c++) begin
      logic [N-1:0]         v;
      logic [N-1:0][AW-1:0] a;
      logic [N-1:0][DW-1:0] d;
      v = N'($urandom);
      for (int k = 0; k < int'(N); k++) begin
        a[k] = ($urandom_range(0, 7) == 0) ? '0 : AW'($urandom_range(1, 12));
        d[k] = $urandom;
      end
      apply(v, a, d);
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
